// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter with one transaction in flight at a time.
// Round-robin between ports; within a port a write request wins over a read.
module axi_lite_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int RESP_WIDTH = 3,
  localparam int STRB_WIDTH = DATA_WIDTH / 8 + 1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  // upstream port 0
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [RESP_WIDTH-1:0] s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [RESP_WIDTH-1:0] s0_axi_rresp,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // upstream port 1
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [RESP_WIDTH-1:0] s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [RESP_WIDTH-1:0] s1_axi_rresp,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // downstream port
  output logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
  output logic                  m0_axi_awvalid,
  input  logic                  m0_axi_awready,
  output logic [DATA_WIDTH-1:0] m0_axi_wdata,
  output logic [STRB_WIDTH-1:0] m0_axi_wstrb,
  output logic                  m0_axi_wvalid,
  input  logic                  m0_axi_wready,
  input  logic [RESP_WIDTH-1:0] m0_axi_bresp,
  input  logic                  m0_axi_bvalid,
  output logic                  m0_axi_bready,
  output logic [ADDR_WIDTH-1:0] m0_axi_araddr,
  output logic                  m0_axi_arvalid,
  input  logic                  m0_axi_arready,
  input  logic [DATA_WIDTH-1:0] m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m0_axi_rresp,
  input  logic                  m0_axi_rvalid,
  output logic                  m0_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_FWD, WR_RESP, WR_BACK, RD_ADDR, RD_DATA, RD_BACK
  } state_t;

  state_t state_reg, state_next;
  logic   gnt_port_reg, gnt_port_next;
  logic   last_grant_reg, last_grant_next;

  logic [1:0] awvalid_in, wvalid_in, arvalid_in, bready_in, rready_in;
  logic [1:0] req_wr, req_rd, req;
  logic       pick, pick_wr;

  logic [1:0] s_awready_reg, s_awready_next, s_wready_reg, s_wready_next;
  logic [1:0] s_arready_reg, s_arready_next;
  logic [1:0] s_bvalid_reg, s_bvalid_next, s_rvalid_reg, s_rvalid_next;
  logic [1:0][RESP_WIDTH-1:0] s_bresp_reg, s_bresp_next, s_rresp_reg, s_rresp_next;
  logic [1:0][DATA_WIDTH-1:0] s_rdata_reg, s_rdata_next;

  logic [ADDR_WIDTH-1:0] m0_awaddr_reg, m0_awaddr_next, m0_araddr_reg, m0_araddr_next;
  logic [DATA_WIDTH-1:0] m0_wdata_reg, m0_wdata_next;
  logic [STRB_WIDTH-1:0] m0_wstrb_reg, m0_wstrb_next;
  logic m0_awvalid_reg, m0_awvalid_next, m0_wvalid_reg, m0_wvalid_next;
  logic m0_bready_reg, m0_bready_next, m0_arvalid_reg, m0_arvalid_next;
  logic m0_rready_reg, m0_rready_next;
  logic aw_pending, w_pending;

  assign awvalid_in = {s1_axi_awvalid, s0_axi_awvalid};
  assign wvalid_in  = {s1_axi_wvalid,  s0_axi_wvalid};
  assign arvalid_in = {s1_axi_arvalid, s0_axi_arvalid};
  assign bready_in  = {s1_axi_bready,  s0_axi_bready};
  assign rready_in  = {s1_axi_rready,  s0_axi_rready};

  // A lone awvalid or wvalid is never treated as a write request.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_req
    assign req_wr[gi] = awvalid_in[gi] & wvalid_in[gi];
    assign req_rd[gi] = arvalid_in[gi];
    assign req[gi]    = req_wr[gi] | req_rd[gi];
  end

  assign pick    = (req[0] & req[1]) ? ~last_grant_reg : req[1];
  assign pick_wr = req_wr[pick];

  assign aw_pending = m0_awvalid_reg & ~m0_axi_awready;
  assign w_pending  = m0_wvalid_reg & ~m0_axi_wready;

  always_comb begin
    state_next      = state_reg;
    gnt_port_next   = gnt_port_reg;
    last_grant_next = last_grant_reg;
    s_awready_next  = '0;
    s_wready_next   = '0;
    s_arready_next  = '0;
    s_bvalid_next   = s_bvalid_reg;
    s_rvalid_next   = s_rvalid_reg;
    s_bresp_next    = s_bresp_reg;
    s_rresp_next    = s_rresp_reg;
    s_rdata_next    = s_rdata_reg;
    m0_awaddr_next  = m0_awaddr_reg;
    m0_wdata_next   = m0_wdata_reg;
    m0_wstrb_next   = m0_wstrb_reg;
    m0_araddr_next  = m0_araddr_reg;
    m0_awvalid_next = m0_awvalid_reg;
    m0_wvalid_next  = m0_wvalid_reg;
    m0_bready_next  = m0_bready_reg;
    m0_arvalid_next = m0_arvalid_reg;
    m0_rready_next  = m0_rready_reg;
    unique case (state_reg)
      IDLE: if (|req) begin
        gnt_port_next = pick;
        if (pick_wr) begin
          state_next            = WR_FWD;
          s_awready_next[pick]  = 1'b1;
          s_wready_next[pick]   = 1'b1;
          m0_awvalid_next       = 1'b1;
          m0_wvalid_next        = 1'b1;
          m0_awaddr_next        = pick ? s1_axi_awaddr : s0_axi_awaddr;
          m0_wdata_next         = pick ? s1_axi_wdata  : s0_axi_wdata;
          m0_wstrb_next         = pick ? s1_axi_wstrb  : s0_axi_wstrb;
        end else begin
          state_next            = RD_ADDR;
          s_arready_next[pick]  = 1'b1;
          m0_arvalid_next       = 1'b1;
          m0_araddr_next        = pick ? s1_axi_araddr : s0_axi_araddr;
        end
      end
      // Address and data channels complete independently, in any order.
      WR_FWD: begin
        m0_awvalid_next = aw_pending;
        m0_wvalid_next  = w_pending;
        if (!aw_pending && !w_pending) begin
          state_next     = WR_RESP;
          m0_bready_next = 1'b1;
        end
      end
      WR_RESP: if (m0_axi_bvalid) begin
        state_next                  = WR_BACK;
        m0_bready_next              = 1'b0;
        s_bresp_next[gnt_port_reg]  = m0_axi_bresp;
        s_bvalid_next[gnt_port_reg] = 1'b1;
      end
      WR_BACK: if (bready_in[gnt_port_reg]) begin
        state_next                  = IDLE;
        s_bvalid_next[gnt_port_reg] = 1'b0;
        last_grant_next             = gnt_port_reg;
      end
      RD_ADDR: if (m0_axi_arready) begin
        state_next      = RD_DATA;
        m0_arvalid_next = 1'b0;
        m0_rready_next  = 1'b1;
      end
      RD_DATA: if (m0_axi_rvalid) begin
        state_next                  = RD_BACK;
        m0_rready_next              = 1'b0;
        s_rdata_next[gnt_port_reg]  = m0_axi_rdata;
        s_rresp_next[gnt_port_reg]  = m0_axi_rresp;
        s_rvalid_next[gnt_port_reg] = 1'b1;
      end
      RD_BACK: if (rready_in[gnt_port_reg]) begin
        state_next                  = IDLE;
        s_rvalid_next[gnt_port_reg] = 1'b0;
        last_grant_next             = gnt_port_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_reg      <= IDLE;
      gnt_port_reg   <= 1'b0;
      last_grant_reg <= 1'b1;
      s_awready_reg  <= '0;
      s_wready_reg   <= '0;
      s_arready_reg  <= '0;
      s_bvalid_reg   <= '0;
      s_rvalid_reg   <= '0;
      s_bresp_reg    <= '0;
      s_rresp_reg    <= '0;
      s_rdata_reg    <= '0;
      m0_awaddr_reg  <= '0;
      m0_wdata_reg   <= '0;
      m0_wstrb_reg   <= '0;
      m0_araddr_reg  <= '0;
      m0_awvalid_reg <= 1'b0;
      m0_wvalid_reg  <= 1'b0;
      m0_bready_reg  <= 1'b0;
      m0_arvalid_reg <= 1'b0;
      m0_rready_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_port_reg   <= gnt_port_next;
      last_grant_reg <= last_grant_next;
      s_awready_reg  <= s_awready_next;
      s_wready_reg   <= s_wready_next;
      s_arready_reg  <= s_arready_next;
      s_bvalid_reg   <= s_bvalid_next;
      s_rvalid_reg   <= s_rvalid_next;
      s_bresp_reg    <= s_bresp_next;
      s_rresp_reg    <= s_rresp_next;
      s_rdata_reg    <= s_rdata_next;
      m0_awaddr_reg  <= m0_awaddr_next;
      m0_wdata_reg   <= m0_wdata_next;
      m0_wstrb_reg   <= m0_wstrb_next;
      m0_araddr_reg  <= m0_araddr_next;
      m0_awvalid_reg <= m0_awvalid_next;
      m0_wvalid_reg  <= m0_wvalid_next;
      m0_bready_reg  <= m0_bready_next;
      m0_arvalid_reg <= m0_arvalid_next;
      m0_rready_reg  <= m0_rready_next;
    end
  end

  assign s0_axi_awready = s_awready_reg[0];
  assign s1_axi_awready = s_awready_reg[1];
  assign s0_axi_wready  = s_wready_reg[0];
  assign s1_axi_wready  = s_wready_reg[1];
  assign s0_axi_arready = s_arready_reg[0];
  assign s1_axi_arready = s_arready_reg[1];
  assign s0_axi_bvalid  = s_bvalid_reg[0];
  assign s1_axi_bvalid  = s_bvalid_reg[1];
  assign s0_axi_bresp   = s_bresp_reg[0];
  assign s1_axi_bresp   = s_bresp_reg[1];
  assign s0_axi_rvalid  = s_rvalid_reg[0];
  assign s1_axi_rvalid  = s_rvalid_reg[1];
  assign s0_axi_rdata   = s_rdata_reg[0];
  assign s1_axi_rdata   = s_rdata_reg[1];
  assign s0_axi_rresp   = s_rresp_reg[0];
  assign s1_axi_rresp   = s_rresp_reg[1];

  assign m0_axi_awaddr  = m0_awaddr_reg;
  assign m0_axi_awvalid = m0_awvalid_reg;
  assign m0_axi_wdata   = m0_wdata_reg;
  assign m0_axi_wstrb   = m0_wstrb_reg;
  assign m0_axi_wvalid  = m0_wvalid_reg;
  assign m0_axi_bready  = m0_bready_reg;
  assign m0_axi_araddr  = m0_araddr_reg;
  assign m0_axi_arvalid = m0_arvalid_reg;
  assign m0_axi_rready  = m0_rready_reg;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: a table of single-port transactions with
// zero-wait downstream, then hand-written sequences for tie-break, backpressure and reset.
module tb_axi_lite_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW / 8 + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] s_awaddr, s_araddr;
  logic [1:0][DW-1:0] s_wdata, s_rdata;
  logic [1:0][SW-1:0] s_wstrb;
  logic [1:0][RW-1:0] s_bresp, s_rresp;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;

  logic [AW-1:0] m0_awaddr, m0_araddr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [SW-1:0] m0_wstrb;
  logic [RW-1:0] m0_bresp, m0_rresp;
  logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;

  axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid),
    .m0_axi_wready(m0_wready), .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid),
    .m0_axi_bready(m0_bready), .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid),
    .m0_axi_arready(m0_arready), .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp),
    .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready)
  );

  typedef struct {
    bit            port;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [RW-1:0] resp;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_resp;
  } vec_t;

  vec_t vecs[4];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
    m0_bvalid = 1'b0; m0_rvalid = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] all_ctrl();
    return 32'({m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready,
                s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
  endfunction

  function automatic logic [31:0] port_ctrl(input bit p);
    return 32'({s_awready[p], s_wready[p], s_arready[p], s_bvalid[p], s_rvalid[p]});
  endfunction

  task automatic set_write(input bit p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_awaddr[p] = a; s_wdata[p] = d; s_wstrb[p] = SW'(5'h0F);
    s_awvalid[p] = 1'b1; s_wvalid[p] = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit p, q;
    p = v.port;
    q = ~v.port;
    if (v.wr) begin
      s_awaddr[p] = v.addr; s_wdata[p] = v.data; s_wstrb[p] = v.strb;
      s_awvalid[p] = 1'b1; s_wvalid[p] = 1'b1;
      tick();  // T+1
      chk("v_awready", 32'(s_awready[p]), 1);
      chk("v_wready", 32'(s_wready[p]), 1);
      chk("v_m0_awvalid", 32'(m0_awvalid), 1);
      chk("v_m0_wvalid", 32'(m0_wvalid), 1);
      chk("v_m0_awaddr", 32'(m0_awaddr), 32'(v.exp_addr));
      chk("v_m0_wdata", m0_wdata, v.exp_data);
      chk("v_m0_wstrb", 32'(m0_wstrb), 32'(v.strb));
      chk("v_other_t1", port_ctrl(q), 0);
      tick();  // T+2
      s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0;
      chk("v_awready_pulse", 32'(s_awready[p]), 0);
      chk("v_m0_awvalid_drop", 32'(m0_awvalid), 0);
      chk("v_m0_bready", 32'(m0_bready), 1);
      m0_bvalid = 1'b1; m0_bresp = v.resp;
      tick();  // T+3
      m0_bvalid = 1'b0;
      chk("v_bvalid", 32'(s_bvalid[p]), 1);
      chk("v_bresp", 32'(s_bresp[p]), 32'(v.exp_resp));
      chk("v_m0_bready_drop", 32'(m0_bready), 0);
      chk("v_other_t3", port_ctrl(q), 0);
      s_bready[p] = 1'b1;
      tick();  // T+4
      s_bready[p] = 1'b0;
      chk("v_bvalid_clear", 32'(s_bvalid[p]), 0);
    end else begin
      s_araddr[p] = v.addr; s_arvalid[p] = 1'b1;
      tick();  // T+1
      chk("v_arready", 32'(s_arready[p]), 1);
      chk("v_m0_arvalid", 32'(m0_arvalid), 1);
      chk("v_m0_araddr", 32'(m0_araddr), 32'(v.exp_addr));
      chk("v_other_t1", port_ctrl(q), 0);
      tick();  // T+2
      s_arvalid[p] = 1'b0;
      chk("v_m0_arvalid_drop", 32'(m0_arvalid), 0);
      chk("v_m0_rready", 32'(m0_rready), 1);
      m0_rvalid = 1'b1; m0_rdata = v.data; m0_rresp = v.resp;
      tick();  // T+3
      m0_rvalid = 1'b0;
      chk("v_rvalid", 32'(s_rvalid[p]), 1);
      chk("v_rdata", s_rdata[p], v.exp_data);
      chk("v_rresp", 32'(s_rresp[p]), 32'(v.exp_resp));
      chk("v_other_t3", port_ctrl(q), 0);
      s_rready[p] = 1'b1;
      tick();  // T+4
      s_rready[p] = 1'b0;
      chk("v_rvalid_clear", 32'(s_rvalid[p]), 0);
    end
    $display("vec %0d: port=%0d %s addr=0x%0h data=0x%0h resp=%0d errors=%0d",
             idx, p, v.wr ? "write" : "read", v.addr, v.data, v.resp, errors);
  endtask

  initial begin
    vecs[0] = '{port: 1'b0, wr: 1'b1, addr: 8'h00, data: 32'd34, strb: 5'h0F, resp: 3'd1,
                exp_addr: 8'h00, exp_data: 32'd34, exp_resp: 3'd1};
    vecs[1] = '{port: 1'b1, wr: 1'b0, addr: 8'h08, data: 32'h17, strb: 5'h00, resp: 3'd1,
                exp_addr: 8'h08, exp_data: 32'h17, exp_resp: 3'd1};
    vecs[2] = '{port: 1'b1, wr: 1'b1, addr: 8'h10, data: 32'd37, strb: 5'h1F, resp: 3'd2,
                exp_addr: 8'h10, exp_data: 32'd37, exp_resp: 3'd2};
    vecs[3] = '{port: 1'b0, wr: 1'b0, addr: 8'hFC, data: 32'hDEADBEEF, strb: 5'h00, resp: 3'd5,
                exp_addr: 8'hFC, exp_data: 32'hDEADBEEF, exp_resp: 3'd5};

    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
    m0_awready = 1'b1; m0_wready = 1'b1; m0_arready = 1'b1;
    m0_bvalid = 1'b0; m0_bresp = '0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0;

    rstn = 1'b0;
    tick(); tick(); tick();
    chk("reset_ctrl", all_ctrl(), 0);
    chk("reset_m0_awaddr", 32'(m0_awaddr), 0);
    chk("reset_s_rdata", s_rdata[0] | s_rdata[1], 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Tie after reset goes to s0, then round-robin to s1, then back to s0.
    do_reset();
    set_write(1'b0, 8'h00, 32'd34);
    set_write(1'b1, 8'h10, 32'd37);
    tick();  // T+1
    chk("tie_s0_awready", 32'(s_awready[0]), 1);
    chk("tie_s1_idle", port_ctrl(1'b1), 0);
    chk("tie_m0_awaddr", 32'(m0_awaddr), 32'h00);
    tick();  // T+2
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    m0_bvalid = 1'b1; m0_bresp = 3'd0;
    tick();  // T+3
    m0_bvalid = 1'b0;
    chk("tie_s0_bvalid", 32'(s_bvalid[0]), 1);
    chk("tie_s1_bvalid", 32'(s_bvalid[1]), 0);
    s_bready[0] = 1'b1;
    tick();  // T+4
    s_bready[0] = 1'b0;
    set_write(1'b0, 8'h04, 32'h99);
    tick();  // T+5
    chk("rr_s1_awready", 32'(s_awready[1]), 1);
    chk("rr_s0_awready", 32'(s_awready[0]), 0);
    chk("rr_m0_awaddr", 32'(m0_awaddr), 32'h10);
    chk("rr_m0_wdata", m0_wdata, 32'd37);
    tick();  // T+6
    s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
    m0_bvalid = 1'b1;
    tick();  // T+7
    m0_bvalid = 1'b0;
    chk("rr_s1_bvalid", 32'(s_bvalid[1]), 1);
    chk("rr_s0_bvalid", 32'(s_bvalid[0]), 0);
    s_bready[1] = 1'b1;
    set_write(1'b1, 8'h14, 32'h77);
    tick();  // T+8
    s_bready[1] = 1'b0;
    tick();  // T+9
    chk("rr2_s0_awready", 32'(s_awready[0]), 1);
    chk("rr2_s1_awready", 32'(s_awready[1]), 0);
    chk("rr2_m0_awaddr", 32'(m0_awaddr), 32'h04);
    $display("seq tie/round-robin: errors=%0d", errors);

    // awready held off for three cycles, wready immediate.
    do_reset();
    m0_awready = 1'b0;
    set_write(1'b0, 8'h30, 32'h1234);
    tick();  // T+1
    chk("bp_awvalid_t1", 32'(m0_awvalid), 1);
    chk("bp_wvalid_t1", 32'(m0_wvalid), 1);
    tick();  // T+2
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    chk("bp_wvalid_drop", 32'(m0_wvalid), 0);
    chk("bp_awvalid_t2", 32'(m0_awvalid), 1);
    tick();  // T+3
    chk("bp_awvalid_t3", 32'(m0_awvalid), 1);
    chk("bp_bready_t3", 32'(m0_bready), 0);
    tick();  // T+4
    m0_awready = 1'b1;
    chk("bp_awvalid_t4", 32'(m0_awvalid), 1);
    tick();  // T+5
    chk("bp_awvalid_done", 32'(m0_awvalid), 0);
    chk("bp_bready_t5", 32'(m0_bready), 1);
    m0_bvalid = 1'b1; m0_bresp = 3'd2;
    tick();  // T+6
    m0_bvalid = 1'b0;
    chk("bp_s0_bresp", 32'(s_bresp[0]), 2);
    s_bready[0] = 1'b1;
    tick();
    s_bready[0] = 1'b0;
    $display("seq aw backpressure: errors=%0d", errors);

    // Same-port write and read: write first, read waits out a stalled bready.
    set_write(1'b0, 8'h40, 32'hAA);
    s_araddr[0] = 8'h44; s_arvalid[0] = 1'b1;
    tick();  // T+1
    chk("wr_first_awready", 32'(s_awready[0]), 1);
    chk("wr_first_arready", 32'(s_arready[0]), 0);
    chk("wr_first_arvalid", 32'(m0_arvalid), 0);
    tick();  // T+2
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    m0_bvalid = 1'b1; m0_bresp = 3'd0;
    tick();  // T+3
    m0_bvalid = 1'b0;
    chk("hold_bvalid_t3", 32'(s_bvalid[0]), 1);
    tick();  // T+4
    chk("hold_bvalid_t4", 32'(s_bvalid[0]), 1);
    chk("hold_no_grant_t4", 32'(s_arready[0] | m0_arvalid), 0);
    tick();  // T+5
    chk("hold_bvalid_t5", 32'(s_bvalid[0]), 1);
    chk("hold_no_grant_t5", 32'(s_arready[0] | m0_arvalid), 0);
    s_bready[0] = 1'b1;
    tick();  // T+6
    s_bready[0] = 1'b0;
    chk("hold_bvalid_clear", 32'(s_bvalid[0]), 0);
    tick();  // T+7
    chk("rd_after_arready", 32'(s_arready[0]), 1);
    chk("rd_after_araddr", 32'(m0_araddr), 32'h44);
    tick();  // T+8
    s_arvalid[0] = 1'b0;
    m0_rvalid = 1'b1; m0_rdata = 32'h55; m0_rresp = 3'd0;
    tick();  // T+9
    m0_rvalid = 1'b0;
    chk("rd_after_rdata", s_rdata[0], 32'h55);
    s_rready[0] = 1'b1;
    tick();
    s_rready[0] = 1'b0;
    $display("seq write+read same port: errors=%0d", errors);

    // Reset while waiting for the write response.
    set_write(1'b1, 8'h20, 32'h42);
    tick();  // T+1
    tick();  // T+2
    s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
    chk("rst_in_wr_resp", 32'(m0_bready), 1);
    rstn = 1'b0;
    m0_bvalid = 1'b1; m0_bresp = 3'd3;
    tick();
    chk("rst_ctrl_zero", all_ctrl(), 0);
    chk("rst_m0_awaddr", 32'(m0_awaddr), 0);
    chk("rst_m0_wdata", m0_wdata, 0);
    tick();
    chk("rst_no_bvalid", 32'(s_bvalid[1]), 0);
    rstn = 1'b1;
    m0_bvalid = 1'b0;
    set_write(1'b0, 8'h50, 32'h1);
    set_write(1'b1, 8'h60, 32'h2);
    tick();
    chk("rst_tie_s0", 32'(s_awready[0]), 1);
    chk("rst_tie_s1", 32'(s_awready[1]), 0);
    chk("rst_tie_addr", 32'(m0_awaddr), 32'h50);
    $display("seq reset in WR_RESP: errors=%0d", errors);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

- Two-master to one-slave AXI-Lite arbiter.
- Sits upstream of the `bus` address decoder: two requesters (ports s0, s1) share the single `bus` slave port through master port m0.
- Exactly one transaction (write or read) is in flight at a time.
- Arbitration is round-robin between ports; within a port, write wins over read.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 8, address width.
- RESP_WIDTH, 3, response width (matches `bus`).

Ports (N = 0,1 for the two upstream slave ports; STRB = DATA_WIDTH/8+1, matching the `bus` strobe port, all bits passed through):
- axi_aclk  input  1  single clock for all ports.
- axi_aresetn  input  1  reset, synchronous, active-low.
- sN_axi_awaddr / sN_axi_awvalid / sN_axi_awready  in / in / out  ADDR_WIDTH / 1 / 1  upstream write address.
- sN_axi_wdata / sN_axi_wstrb / sN_axi_wvalid / sN_axi_wready  in / in / in / out  DATA_WIDTH / STRB / 1 / 1  upstream write data.
- sN_axi_bresp / sN_axi_bvalid / sN_axi_bready  out / out / in  RESP_WIDTH / 1 / 1  upstream write response.
- sN_axi_araddr / sN_axi_arvalid / sN_axi_arready  in / in / out  ADDR_WIDTH / 1 / 1  upstream read address.
- sN_axi_rdata / sN_axi_rresp / sN_axi_rvalid / sN_axi_rready  out / out / out / in  DATA_WIDTH / RESP_WIDTH / 1 / 1  upstream read data.
- m0_axi_aw*, m0_axi_w*, m0_axi_b*, m0_axi_ar*, m0_axi_r*  mirror of the sN set with directions reversed  same widths  downstream port to `bus`.

## Operation
Request qualification:
- Port write request: awvalid AND wvalid both high in the same cycle.
- Port read request: arvalid high.
- Port requests if either is true.

Arbitration (IDLE only):
- last_grant register; reset value 1, so port 0 wins the first tie.
- If both ports request, grant the port that is not last_grant. Otherwise grant the single requester.
- Within the granted port: write if its write request is high, else read.
- last_grant is updated to the granted port when the transaction completes (return to IDLE).

On grant:
- Register awaddr/wdata/wstrb or araddr from the granted port.
- Record gnt_port and gnt_type.

States:
- IDLE: no request -> stay. Write grant -> WR_FWD. Read grant -> RD_ADDR.
- WR_FWD:
  - m0 awvalid and wvalid start high.
  - Each drops independently after its own handshake (awvalid&awready, wvalid&wready).
  - When both are done (same or different cycles) -> WR_RESP.
- WR_RESP: m0_bready=1. On m0_bvalid, capture bresp -> WR_BACK.
- WR_BACK: s[gnt]_bvalid=1 with the captured bresp. On s[gnt]_bready -> IDLE.
- RD_ADDR: m0_arvalid=1. On m0_arready -> RD_DATA.
- RD_DATA: m0_rready=1. On m0_rvalid, capture rdata/rresp -> RD_BACK.
- RD_BACK: s[gnt]_rvalid=1 with the captured data. On s[gnt]_rready -> IDLE.

Port isolation and boundary conditions:
- The non-granted port's ready/valid outputs stay 0 for the whole transaction.
- Its requests stay pending (no drop, no reorder).
- A port holding awvalid without wvalid (or the reverse) is not a write request and is never granted a write.
- Simultaneous write+read from the same port: write first. The read is granted on the next IDLE if still asserted, subject to round-robin.

## Timing
- All outputs are registered.
- Reset value of every output (all valid/ready signals, m0 addr/data/strb, sN bresp/rdata/rresp): 0. Reset also sets state=IDLE, last_grant=1.
- Reset mid-transaction: the in-flight transaction is abandoned with no upstream response. Outputs return to 0 on the next edge.
- Grant cycle: request sampled in cycle T. In cycle T+1:
  - s[gnt]_awready and wready are both high for exactly one cycle (reads: s[gnt]_arready is high for exactly one cycle).
  - m0 awvalid/wvalid (or arvalid) go high.
- Upstream address/data must be held stable while valid, per AXI; the value captured at T equals the value accepted at T+1.
- Minimum write (downstream zero-wait, bready held high):
  - T: request.
  - T+1: m0 handshake.
  - T+2: m0_bready, bvalid seen.
  - T+3: s_bvalid, bready seen.
  - T+4: IDLE, new request sampled.
- Minimum read: same 4-cycle shape (RD_ADDR, RD_DATA, RD_BACK).
- Backpressure on any channel stretches only the state waiting on it. No timeout.
- Every state except IDLE holds until its handshake completes.

## Test plan
1. s0 write awaddr=0x00, wdata=34, wstrb=0xF, zero-wait downstream, m0_bresp=1 -> m0_awaddr=0x00, m0_wdata=34 in cycle T+1; s0_bvalid with bresp=1 in cycle T+3; s1 outputs all 0.
2. s0 and s1 both write at T (addr 0x00/34 and 0x10/37) -> s0 granted first (reset tie-break), s1 forwarded at T+5; next tie grants s0 again.
3. s1 read araddr=0x08, m0_rdata=0x17, rresp=1 -> m0_araddr=0x08 at T+1; s1_rvalid, rdata=0x17, rresp=1 at T+3.
4. Downstream awready delayed 3 cycles, wready immediate -> m0_wvalid drops after 1 cycle; m0_awvalid stays high until awready; WR_RESP entered the cycle after the aw handshake.
5. s0 asserts write and read together, s1 idle -> write completes first, then read granted; s0_bready held low 2 cycles -> s0_bvalid held, no new grant until accepted.
6. axi_aresetn low in WR_RESP -> all outputs 0 on the next edge; no s*_bvalid; first post-reset tie grants s0.
